// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one word memory: fetch (port 0) and load/store (port 1).
// Define ARB_ROUND_ROBIN_EN for alternating tie grants; the default build gives port 0 fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              nextState;
  logic                anyReq;
  logic                tieWinner;
  logic                winner;
  logic                latWe;
  logic [ADDR_W-1:0]   latAdr;
  logic [DATA_W-1:0]   latWdata;

  assign anyReq = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
  assign tieWinner = ~owner;
`else
  assign tieWinner = 1'b0;
`endif

  // A lone requester wins outright; only a tie consults the policy.
  assign winner = (req0 && req1) ? tieWinner : req1;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ACCESS;
      ACCESS:  nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b1;
      latWe    <= 1'b0;
      latAdr   <= '0;
      latWdata <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && anyReq) begin
        owner    <= winner;
        latWe    <= winner ? we1 : we0;
        latAdr   <= winner ? adr1 : adr0;
        latWdata <= winner ? wdata1 : wdata0;
      end
      // Per-port response registers: only the owner's copy is refreshed, the other holds.
      if (state == ACCESS) begin
        if (owner) rdata1 <= mem_rdata;
        else       rdata0 <= mem_rdata;
      end
    end
  end

  // Memory address/data come straight from the latches so they hold between accesses.
  assign mem_adr   = latAdr;
  assign mem_wdata = latWdata;
  assign mem_we    = (state == ACCESS) && latWe;

  assign busy     = (state != IDLE);
  assign ack0     = (state == RESP) && !owner;
  assign ack1     = (state == RESP) && owner;
  assign misalign = (state == RESP) && (latAdr[1:0] != 2'b00);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized traffic
// compared against a transaction-level model of grants and memory contents.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] adr0, adr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, misalign, mem_we, busy, owner;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_adr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .misalign(misalign), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Shared word memory: 64 words, combinational read, word-indexed by adr[7:2].
  logic [DW-1:0] mem [0:63];
  logic          memClear;

  function automatic logic [DW-1:0] initWord(input int i);
    return 32'hA500_0000 | (32'(i) * 32'h0000_0101);
  endfunction

  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
    end else if (mem_we) begin
      mem[mem_adr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_adr[7:2]];

  // Transaction-level reference model.
  logic [DW-1:0] refMem [0:63];
  logic          pReq  [2];
  logic          pWe   [2];
  logic [AW-1:0] pAdr  [2];
  logic [DW-1:0] pData [2];
  logic [DW-1:0] expRdata [2];
  int            lastGrant;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic setPort(input int p, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] data);
    pReq[p] = 1'b1; pWe[p] = we; pAdr[p] = adr; pData[p] = data;
    if (p == 0) begin req0 = 1'b1; we0 = we; adr0 = adr; wdata0 = data; end
    else        begin req1 = 1'b1; we1 = we; adr1 = adr; wdata1 = data; end
  endtask

  task automatic dropPort(input int p);
    pReq[p] = 1'b0;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  function automatic int pickWinner();
    if (pReq[0] && pReq[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      return 1 - lastGrant;
`else
      return 0;
`endif
    end
    return pReq[1] ? 1 : 0;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    dropPort(0);
    dropPort(1);
    @(negedge clk);
    rst = 1'b0;
    lastGrant = 1;
    expRdata[0] = '0;
    expRdata[1] = '0;
  endtask

  // Called at a negedge in an IDLE cycle; services every pending request.
  task automatic runPending();
    int            w;
    logic [DW-1:0] old;
    logic [5:0]    idx;
    while (pReq[0] || pReq[1]) begin
      w   = pickWinner();
      idx = pAdr[w][7:2];
      old = refMem[idx];
      @(negedge clk);
      check("acc_busy", busy, 1);
      check("acc_mem_we", mem_we, pWe[w]);
      check("acc_mem_adr", mem_adr, pAdr[w]);
      if (pWe[w]) check("acc_mem_wdata", mem_wdata, pData[w]);
      check("acc_no_ack", {ack1, ack0}, 0);
      check("acc_owner", owner, 64'(w));
      @(negedge clk);
      expRdata[w] = old;
      check("rsp_ack0", ack0, (w == 0));
      check("rsp_ack1", ack1, (w == 1));
      check("rsp_rdata0", rdata0, expRdata[0]);
      check("rsp_rdata1", rdata1, expRdata[1]);
      check("rsp_misalign", misalign, (pAdr[w][1:0] != 2'b00));
      check("rsp_mem_we", mem_we, 0);
      if (pWe[w]) refMem[idx] = pData[w];
      lastGrant = w;
      dropPort(w);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_no_ack", {ack1, ack0}, 0);
    end
  endtask

  initial begin
    int            k, ackIdx, expPort;
    logic [1:0]    mask;
    logic [AW-1:0] a;

    rst = 1'b1; memClear = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
    for (int p = 0; p < 2; p++) begin
      pReq[p] = 0; pWe[p] = 0; pAdr[p] = '0; pData[p] = '0; expRdata[p] = '0;
    end
    lastGrant = 1;

    repeat (2) @(negedge clk);
    memClear = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 1);
    check("rst_acks", {ack1, ack0}, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_misalign", misalign, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Port 1 write, then port 0 read-back, then a misaligned read.
    setPort(1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    runPending();
    check("wr40_mem", mem[16], 32'hDEAD_BEEF);
    setPort(0, 1'b0, 32'h40, 32'h0);
    runPending();
    check("rd40_rdata0", rdata0, 32'hDEAD_BEEF);
    setPort(0, 1'b0, 32'h43, 32'h0);
    runPending();

    // Randomized traffic, single and simultaneous requesters.
    for (int it = 0; it < 40; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
          if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
          setPort(p, 1'($urandom_range(0, 1)), a, $urandom);
        end
      end
      runPending();
    end

    // Reset during the ACCESS cycle of a write must suppress it without an ack.
    setPort(0, 1'b1, 32'h80, 32'h1234_5678);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstacc_mem_we", mem_we, 0);
    check("rstacc_busy", busy, 0);
    check("rstacc_ack0", ack0, 0);
    @(negedge clk);
    rst = 1'b0;
    dropPort(0);
    lastGrant = 1;
    expRdata[0] = '0;
    expRdata[1] = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstacc_no_ack", {ack1, ack0}, 0);
      check("rstacc_idle", busy, 0);
    end
    check("rstacc_mem80", mem[32], refMem[32]);
    setPort(0, 1'b0, 32'h80, 32'h0);
    runPending();

    // Both ports requesting continuously from a fresh reset.
    doReset();
    setPort(0, 1'b0, 32'h10, 32'h0);
    setPort(1, 1'b0, 32'h20, 32'h0);
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      ackIdx = (k - 2) / 3;
`ifdef ARB_ROUND_ROBIN_EN
      expPort = ackIdx % 2;
`else
      expPort = 0;
`endif
      check("cont_ack0", ack0, (k % 3 == 2) && (expPort == 0));
      check("cont_ack1", ack1, (k % 3 == 2) && (expPort == 1));
      if (k % 3 == 2) begin
        if (expPort == 0) check("cont_rdata0", rdata0, refMem[4]);
        else              check("cont_rdata1", rdata1, refMem[8]);
      end
    end
    dropPort(0);
    dropPort(1);
    repeat (3) @(negedge clk);
    check("end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the width of all address ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the width of all data ports.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have ports req0/req1, input, 1 bit each: access request from port 0 (fetch) and port 1 (load/store).
REQ-006 The block SHALL have ports we0/we1, input, 1 bit each: request is a write when 1.
REQ-007 The block SHALL have ports adr0/adr1, input, ADDR_W each: byte address of the request.
REQ-008 The block SHALL have ports wdata0/wdata1, input, DATA_W each: write data.
REQ-009 The block SHALL have ports ack0/ack1, output, 1 bit each: one-cycle completion pulse.
REQ-010 The block SHALL have ports rdata0/rdata1, output, DATA_W each: read data, valid in the ack cycle.
REQ-011 The block SHALL have port misalign, output, 1 bit: pulses with ack when the serviced address has adr[1:0] != 0.
REQ-012 The block SHALL have ports mem_adr (ADDR_W), mem_wdata (DATA_W) and mem_we (1 bit), outputs to the shared word memory.
REQ-013 The block SHALL have port mem_rdata, input, DATA_W: combinational read data from the shared memory.
REQ-014 The block SHALL have ports busy (1 bit, high when state != IDLE) and owner (1 bit, index of the current or last granted port), outputs.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCESS and RESP, with the transitions IDLE->ACCESS when any req is high, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-016 In IDLE with a request pending, the block SHALL select a winner and latch its we, adr and wdata, and SHALL set owner to the winner.
REQ-017 In ACCESS, the block SHALL drive mem_adr and mem_wdata from the latched values and SHALL assert mem_we exactly that one cycle if the latched we is 1.
REQ-018 In ACCESS, the block SHALL register mem_rdata into a response register, for reads and writes alike.
REQ-019 In RESP, the block SHALL pulse ack of the owner only and SHALL drive that port's rdata from the response register; the other port's rdata SHALL hold its last value.
REQ-020 Latency SHALL be fixed: a request sampled in IDLE at edge N SHALL produce mem_we in cycle N+1 and ack in cycle N+2; throughput SHALL be one access per 3 cycles.
REQ-021 A requester SHALL hold req, we, adr and wdata stable until ack; the block SHALL ignore input changes after latching.
REQ-022 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-023 The block SHALL forward adr unmodified; word alignment SHALL be the memory's job. misalign SHALL be informational only, and the access SHALL still complete.
REQ-024 Outside ACCESS, mem_we SHALL be 0, and mem_adr and mem_wdata SHALL hold their last latched values.

Reset
REQ-025 While rst is high, the block SHALL asynchronously force: state IDLE; ack0, ack1, misalign, mem_we and busy to 0; owner to 1 (so port 0 wins the first tie); and all latches, mem_adr, mem_wdata, rdata0 and rdata1 to 0.
REQ-026 A reset asserted during ACCESS SHALL suppress any pending write and SHALL drop the request without an ack; the requester SHALL re-request.

Configuration
REQ-027 With macro ARB_ROUND_ROBIN_EN defined, ties SHALL be granted to the port that is not owner (alternating grants).
REQ-028 Without ARB_ROUND_ROBIN_EN, port 0 SHALL always win ties (fixed priority).
REQ-029 In both configurations, a single requester SHALL be granted immediately.

Verification
REQ-030 The bench SHALL check: after reset, req1=1, we1=1, adr1=0x40, wdata1=0xDEADBEEF -> mem_we=1 with mem_adr=0x40 in cycle +1, ack1 in cycle +2, misalign=0.
REQ-031 The bench SHALL check: read port 0 at 0x40 after the write above -> ack0 at +2, rdata0=0xDEADBEEF.
REQ-032 The bench SHALL check: req0 and req1 held high continuously with ARB_ROUND_ROBIN_EN defined -> grant order 0,1,0,1, with an ack every 3 cycles.
REQ-033 The bench SHALL check: the same stimulus without the macro -> ack0 every 3 cycles and ack1 never.
REQ-034 The bench SHALL check: rst pulsed during the ACCESS cycle of a write to 0x80 -> no mem_we, no ack, memory at 0x80 unchanged, state IDLE.
REQ-035 The bench SHALL check: a read from adr0=0x43 -> mem_adr=0x43, with ack0 and misalign high in the same cycle.
